// File: rtl/onehot_count_checker.sv
// Receive-side checker: encodes a one-hot decoder bus back to a count,
// verifies +1 mod N sequencing with lock detection and tallies errors.
module onehot_count_checker #(
    parameter int N_LINES    = 8,
    parameter int CNT_W      = 3,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic               clockpulse,
    input  logic               clear_,
    input  logic [N_LINES-1:0] decoder_in,
    input  logic               in_valid,
    output logic [CNT_W-1:0]   enc_out,
    output logic               enc_valid,
    output logic               onehot_err,
    output logic               seq_err,
    output logic               locked,
    output logic [ERR_W-1:0]   err_count
);

    localparam int MC_W = 4;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic             ref_vld_q, ref_vld_d;
    logic [MC_W-1:0]  mcnt_q, mcnt_d;

    logic [CNT_W-1:0] enc_d;
    logic             enc_valid_d;
    logic             onehot_err_d;
    logic             seq_err_d;
    logic [ERR_W-1:0] err_d;

    logic [CNT_W:0]   ones;
    logic [CNT_W-1:0] idx;
    logic             legal;
    logic             step_ok;
    logic             bump;

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < N_LINES; i++) begin
            if (decoder_in[i]) begin
                ones = ones + (CNT_W+1)'(1);
                idx  = CNT_W'(i);
            end
        end
    end

    assign legal   = (ones == (CNT_W+1)'(1));
    // Counter width equals log2(N_LINES), so the add wraps 7->0 by itself.
    assign step_ok = ref_vld_q && (idx == ref_q + CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        ref_d        = ref_q;
        ref_vld_d    = ref_vld_q;
        mcnt_d       = mcnt_q;
        enc_d        = enc_out;
        enc_valid_d  = 1'b0;
        onehot_err_d = 1'b0;
        seq_err_d    = 1'b0;
        bump         = 1'b0;

        if (in_valid) begin
            if (!legal) begin
                onehot_err_d = 1'b1;
                bump         = 1'b1;
                state_d      = UNLOCKED;
                ref_vld_d    = 1'b0;
                mcnt_d       = '0;
            end else begin
                enc_d       = idx;
                enc_valid_d = 1'b1;
                ref_d       = idx;
                ref_vld_d   = 1'b1;
                unique case (state_q)
                    UNLOCKED: begin
                        if (step_ok) begin
                            mcnt_d = mcnt_q + MC_W'(1);
                            if (mcnt_d >= MC_W'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                                mcnt_d  = '0;
                            end
                        end else begin
                            mcnt_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (!step_ok) begin
                            seq_err_d = 1'b1;
                            bump      = 1'b1;
                            state_d   = UNLOCKED;
                            mcnt_d    = '0;
                        end
                    end
                    default: state_d = UNLOCKED;
                endcase
            end
        end

        err_d = err_count;
        if (bump && (err_count != {ERR_W{1'b1}})) begin
            err_d = err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clockpulse) begin
        if (!clear_) begin
            state_q    <= UNLOCKED;
            ref_q      <= '0;
            ref_vld_q  <= 1'b0;
            mcnt_q     <= '0;
            enc_out    <= '0;
            enc_valid  <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            ref_vld_q  <= ref_vld_d;
            mcnt_q     <= mcnt_d;
            enc_out    <= enc_d;
            enc_valid  <= enc_valid_d;
            onehot_err <= onehot_err_d;
            seq_err    <= seq_err_d;
            err_count  <= err_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: doc/onehot_count_checker.md
Name: onehot_count_checker

Overview:
- Receive-side counterpart of the 3-bit counter + 3-to-8 decoder datapath.
- Accepts the 8-line one-hot decoder bus and encodes it back to a 3-bit count.
- Checks that successive samples advance by exactly +1 modulo 8, and locks onto a correct sequence.
- Reports malformed one-hot words and sequence breaks, and keeps a saturating error tally for board-level LED/7-seg display.

Parameters:
- N_LINES, 8, width of the one-hot input bus; must be a power of 2.
- CNT_W, 3, encoded count width (log2 N_LINES).
- LOCK_COUNT, 2, consecutive correct +1 steps required to enter LOCKED; range 1..15.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clockpulse  input  1  single clock; all state updates on its rising edge.
- clear_  input  1  synchronous, active-low reset.
- decoder_in  input  N_LINES  one-hot word from the decoder.
- in_valid  input  1  decoder_in is sampled only when 1.
- enc_out  output  CNT_W  last valid encoded count.
- enc_valid  output  1  1-cycle pulse: enc_out was updated from a legal one-hot word.
- onehot_err  output  1  1-cycle pulse: sampled word had zero or more than one bit set.
- seq_err  output  1  1-cycle pulse: sequence break detected while LOCKED.
- locked  output  1  level; 1 while the FSM is in LOCKED.
- err_count  output  ERR_W  saturating count of onehot_err plus seq_err events.

Behaviour:
- Reset: clear_=0 at a rising edge clears all outputs and internal state to 0 on that edge. The FSM goes to UNLOCKED with no reference value held.
  - Reset has priority over every other input.
  - A mid-operation reset discards lock and error history.
- All outputs are registered. Response appears 1 cycle after the sampling edge.
- in_valid=0: no state change. enc_out, locked and err_count hold. All pulses are 0.
- Encode: index of the single set bit. Bit k maps to enc_out=k (bit0 maps to 0).
- Illegal word (popcount != 1) with in_valid=1:
  - onehot_err=1 for one cycle.
  - enc_out holds; enc_valid=0.
  - err_count increments.
  - FSM goes to UNLOCKED and the reference is invalidated.
  - seq_err=0, even if the FSM was LOCKED.
- Legal word v: enc_out<=v and enc_valid=1. Expected value = (ref+1) mod N_LINES. Wrap 7->0 is a correct step.
- FSM state UNLOCKED:
  - No reference held: ref<=v, match_cnt<=0.
  - v==expected: ref<=v and match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED; locked=1 in the same cycle as that step's enc_valid.
  - v!=expected: ref<=v, match_cnt<=0, no seq_err.
- FSM state LOCKED:
  - v==expected: ref<=v, stay in LOCKED.
  - v!=expected (including a repeated value): seq_err=1, err_count++, go to UNLOCKED, ref<=v, match_cnt<=0.
- err_count saturates at 2^ERR_W-1 and never wraps. onehot_err and seq_err are mutually exclusive by construction, so each event adds exactly 1.
- Gaps in in_valid do not affect lock; checking resumes on the next valid sample.

Test Plan:
- Reset then clean stream: clear_=0 for 2 cycles, then feed 0x01,0x02,0x04,... one per cycle with in_valid=1.
  - enc_out follows 0,1,2,... one cycle later.
  - locked=1 together with the third sample (enc_out=2).
  - err_count=0 throughout.
- Wrap: while LOCKED, drive 0x40,0x80,0x01 -> enc_out 6,7,0; locked stays 1; seq_err never asserts.
- Skip: while LOCKED at enc_out=3, drive 0x20 (value 5).
  - seq_err pulses 1 cycle; locked=0; err_count=1.
  - Continuing 0x40,0x80 relocks with enc_out=7.
- Illegal words: drive 0x00, then 0x03.
  - onehot_err pulses on each; enc_out holds its prior value; err_count +2.
  - A following legal 0x01 gives enc_valid=1 and enc_out=0 with no seq_err.
- Saturation: with ERR_W=8, inject 300 illegal words -> err_count stops at 255.
- Reset mid-run / valid gaps:
  - clear_=0 for 1 cycle while LOCKED with err_count=4 -> next cycle all outputs 0, locked=0.
  - Separately, deasserting in_valid for 5 cycles mid-sequence keeps locked=1 and enc_out unchanged.
